// File: rtl/net1_tester_if.sv
// Stimulus/response and control/status bundle between net1_tester, the net1
// block under test and whatever issues start and reads the verdict.
interface net1_tester_if;
    logic       start;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] error_count;
    logic [3:0] first_fail;
    logic       a;
    logic       b;
    logic       c;
    logic       d;
    logic       x;
    logic       y;
    logic       z;

    modport slave (
        input  start, x, y, z,
        output busy, done, pass, error_count, first_fail, a, b, c, d
    );

    modport master (
        output start, x, y, z,
        input  busy, done, pass, error_count, first_fail, a, b, c, d
    );
endinterface

// File: rtl/net1_tester.sv
// Self-test sequencer for net1 (x = a^b, y = d, z = cd + b'd'): sweeps all 16
// vectors, compares each response with a golden value and reports the verdict.
//
// state  | meaning
// IDLE   | waiting for start; last sweep result held
// SETTLE | current vector held on a..d while net1 settles
// SAMPLE | x/y/z compared with golden at the closing edge
// DONE   | one-cycle done pulse; pass valid
module net1_tester #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic          clock,
    input  logic          reset_n,
    net1_tester_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] ff_q, ff_d;
    logic [4:0] err_q, err_d;
    logic       pass_q, pass_d;
    logic       ex, ey, ez, mismatch;

    always_comb begin
        ex       = vec_q[3] ^ vec_q[2];
        ey       = vec_q[0];
        ez       = (vec_q[1] & vec_q[0]) | (~vec_q[2] & ~vec_q[0]);
        mismatch = (bus.x != ex) || (bus.y != ey) || (bus.z != ez);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            vec_q   <= 4'd0;
            cnt_q   <= 4'd0;
            ff_q    <= 4'd0;
            err_q   <= 5'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            ff_q    <= ff_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        ff_d    = ff_q;
        err_d   = err_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    vec_d   = 4'd0;
                    err_d   = 5'd0;
                    ff_d    = 4'd0;
                    pass_d  = 1'b0;
                    cnt_d   = CNT_LOAD;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    err_d = err_q + 5'd1;
                    // err_q is cleared at acceptance, so zero marks the first miss
                    if (err_q == 5'd0) begin
                        ff_d = vec_q;
                    end
                end
                if (vec_q != 4'd15) begin
                    vec_d   = vec_q + 4'd1;
                    cnt_d   = CNT_LOAD;
                    state_d = SETTLE;
                end else begin
                    vec_d   = 4'd0;
                    pass_d  = (err_d == 5'd0);
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.a           = vec_q[3];
    assign bus.b           = vec_q[2];
    assign bus.c           = vec_q[1];
    assign bus.d           = vec_q[0];
    assign bus.busy        = (state_q == SETTLE) || (state_q == SAMPLE);
    assign bus.done        = (state_q == DONE);
    assign bus.pass        = pass_q;
    assign bus.error_count = err_q;
    assign bus.first_fail  = ff_q;
endmodule

// File: tb/tb_net1_tester.sv
// Directed and randomized bench for net1_tester driving a faultable net1 model.
module tb_net1_tester;
    localparam int S = 1;
    localparam int VEC_CYC = S + 1;

    logic clk;
    logic rst_n;
    int   fault;
    logic [2:0] flip [16];
    int   n_cmp;
    int   n_bad;

    net1_tester_if bus ();

    net1_tester #(.SETTLE_CYCLES(S)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // net1 under test, with selectable faults: 1 z stuck-0, 2 y stuck-0, 3 x inverted, 4 random flips
    always_comb begin
        logic [2:0] o;
        o = {bus.a ^ bus.b, bus.d, (bus.c & bus.d) | (~bus.b & ~bus.d)};
        case (fault)
            1: o[0] = 1'b0;
            2: o[1] = 1'b0;
            3: o[2] = ~o[2];
            4: o = o ^ flip[{bus.a, bus.b, bus.c, bus.d}];
            default: ;
        endcase
        {bus.x, bus.y, bus.z} = o;
    end

    function automatic logic [2:0] model_out(input logic [3:0] v, input int f);
        logic [2:0] o;
        o = {v[3] ^ v[2], v[0], (v[1] & v[0]) | (~v[2] & ~v[0])};
        if (f == 1) o[0] = 1'b0;
        if (f == 2) o[1] = 1'b0;
        if (f == 3) o[2] = ~o[2];
        if (f == 4) o = o ^ flip[v];
        return o;
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_abcd"}, {bus.a, bus.b, bus.c, bus.d}, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_pass"}, bus.pass, 0);
        chk({tag, "_err"}, bus.error_count, 0);
        chk({tag, "_ff"}, bus.first_fail, 0);
    endtask

    // full sweep from acceptance to done; mid >= 1 pulses start during the sweep
    task automatic sweep(input int f, input int mid);
        int ee;
        int ef;
        ee = 0;
        ef = 0;
        for (int v = 0; v < 16; v++) begin
            if (model_out(4'(v), f) != model_out(4'(v), 0)) begin
                if (ee == 0) ef = v;
                ee++;
            end
        end
        fault = f;
        @(negedge clk);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int j = 0; j < 16 * VEC_CYC; j++) begin
            if (j > 0) step();
            bus.start = (j == mid);
            chk("sweep_abcd", {bus.a, bus.b, bus.c, bus.d}, j / VEC_CYC);
            chk("sweep_busy", bus.busy, 1);
            chk("sweep_done_early", bus.done, 0);
        end
        step();
        bus.start = 1'b0;
        chk("done_pulse", bus.done, 1);
        chk("done_busy", bus.busy, 0);
        chk("done_abcd", {bus.a, bus.b, bus.c, bus.d}, 0);
        chk("done_err", bus.error_count, ee);
        chk("done_pass", bus.pass, (ee == 0) ? 1 : 0);
        if (ee != 0) chk("done_first_fail", bus.first_fail, ef);
        step();
        chk("done_one_cycle", bus.done, 0);
        chk("idle_err_held", bus.error_count, ee);
    endtask

    initial begin
        int seen;
        n_cmp = 0;
        n_bad = 0;
        fault = 0;
        for (int i = 0; i < 16; i++) flip[i] = 3'd0;
        bus.start = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk_reset_vals("reset");

        sweep(0, -1);
        sweep(1, -1);
        sweep(2, -1);
        sweep(3, -1);
        sweep(0, 10);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++)
                flip[i] = ($urandom_range(0, 2) == 0) ? 3'(($urandom_range(1, 7))) : 3'd0;
            sweep(4, (r == 1) ? int'($urandom_range(1, 30)) : -1);
        end

        // reset in mid-sweep, z stuck-at-0
        fault = 1;
        @(negedge clk);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int j = 0; j < 8 * VEC_CYC; j++) step();
        chk("pre_reset_err", bus.error_count, 4);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_reset_vals("mid_reset");
        seen = 0;
        for (int j = 0; j < 40; j++) begin
            step();
            if (bus.done || bus.busy) seen++;
        end
        chk("post_reset_quiet", seen, 0);
        sweep(1, -1);

        // start held high: back-to-back sweeps
        fault = 0;
        @(negedge clk);
        bus.start = 1'b1;
        step();
        for (int j = 1; j <= 16 * VEC_CYC; j++) step();
        chk("b2b_done1", bus.done, 1);
        chk("b2b_pass1", bus.pass, 1);
        step();
        chk("b2b_idle_busy", bus.busy, 0);
        chk("b2b_idle_done", bus.done, 0);
        step();
        bus.start = 1'b0;
        chk("b2b_accept_busy", bus.busy, 1);
        chk("b2b_accept_pass", bus.pass, 0);
        chk("b2b_accept_err", bus.error_count, 0);
        seen = 0;
        for (int j = 0; j < 100 && !seen; j++) begin
            step();
            if (bus.done) seen = 1;
        end
        chk("b2b_done2_seen", seen, 1);
        chk("b2b_pass2", bus.pass, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
